// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide, 1-cycle-latency RAM port between instruction fetch and load/store.
// Ports:
//   clk_in, rst_n_in                  clock, asynchronous active-low reset
//   if_req_in, if_addr_in             fetch request (always a 4-byte read) and base address
//   if_done_out, if_data_out          one-cycle completion pulse and little-endian fetched word
//   ls_req_in, ls_we_in, ls_size_in   load/store request, write enable, size (00=1B, 01=2B, else 4B)
//   ls_addr_in, ls_wdata_in           load/store base address and write data
//   ls_done_out, ls_rdata_out         one-cycle completion pulse and zero-extended read data
//   ram_en_out, ram_r_nw_out          RAM enable and read(1)/write(0) select
//   ram_a_out, ram_d_out, ram_d_in    RAM byte address, write data, read data (previous cycle's address)
module mem_arbiter #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  ls_req_in,
    input  logic                  ls_we_in,
    input  logic [1:0]            ls_size_in,
    input  logic [ADDR_WIDTH-1:0] ls_addr_in,
    input  logic [31:0]           ls_wdata_in,
    output logic                  ls_done_out,
    output logic [31:0]           ls_rdata_out,
    output logic                  ram_en_out,
    output logic                  ram_r_nw_out,
    output logic [ADDR_WIDTH-1:0] ram_a_out,
    output logic [7:0]            ram_d_out,
    input  logic [7:0]            ram_d_in
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t                state;
    logic [2:0]            cnt, n, req_n;
    logic                  gnt_ls, last_ls, pick_if, wr_req;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata, rbuf, rd_word;
    logic [1:0]            bidx;

    // cnt holds the index of the current RD/WR cycle (1-based); read bytes arrive one cycle
    // late, so the byte landing in cycle cnt belongs to position cnt-2.
    always_comb begin
        pick_if = if_req_in && (!ls_req_in || last_ls);
        wr_req  = !pick_if && ls_we_in;
        req_n   = ls_size_in == 2'b00 ? 3'd1 : ls_size_in == 2'b01 ? 3'd2 : 3'd4;
        bidx    = 2'(cnt - 3'd2);
        rd_word = rbuf;
        rd_word[{bidx, 3'b000} +: 8] = ram_d_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            cnt          <= '0;
            n            <= '0;
            gnt_ls       <= 1'b0;
            last_ls      <= 1'b1;
            base         <= '0;
            wdata        <= '0;
            rbuf         <= '0;
            if_done_out  <= 1'b0;
            if_data_out  <= '0;
            ls_done_out  <= 1'b0;
            ls_rdata_out <= '0;
            ram_en_out   <= 1'b0;
            ram_r_nw_out <= 1'b0;
            ram_a_out    <= '0;
            ram_d_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ram_r_nw_out <= 1'b1;
                    if (if_req_in || ls_req_in) begin
                        gnt_ls       <= !pick_if;
                        last_ls      <= !pick_if;
                        base         <= pick_if ? if_addr_in : ls_addr_in;
                        n            <= pick_if ? 3'd4 : req_n;
                        wdata        <= ls_wdata_in;
                        rbuf         <= '0;
                        cnt          <= 3'd1;
                        state        <= wr_req ? WR : RD;
                        ram_en_out   <= 1'b1;
                        ram_r_nw_out <= !wr_req;
                        ram_a_out    <= pick_if ? if_addr_in : ls_addr_in;
                        ram_d_out    <= wr_req ? ls_wdata_in[7:0] : 8'h00;
                    end
                end
                RD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt >= 3'd2) rbuf <= rd_word;
                    // after the last address the port stays enabled one extra cycle to collect the final byte
                    if (cnt < n) ram_a_out <= base + ADDR_WIDTH'(cnt);
                    if (cnt == n + 3'd1) begin
                        state      <= DONE;
                        ram_en_out <= 1'b0;
                        ram_a_out  <= '0;
                        if (gnt_ls) begin
                            ls_done_out  <= 1'b1;
                            ls_rdata_out <= rd_word;
                        end else begin
                            if_done_out <= 1'b1;
                            if_data_out <= rd_word;
                        end
                    end
                end
                WR: begin
                    cnt <= cnt + 3'd1;
                    if (cnt < n) begin
                        ram_a_out <= base + ADDR_WIDTH'(cnt);
                        ram_d_out <= wdata[{cnt[1:0], 3'b000} +: 8];
                    end else begin
                        state        <= DONE;
                        ram_en_out   <= 1'b0;
                        ram_r_nw_out <= 1'b1;
                        ram_a_out    <= '0;
                        ram_d_out    <= '0;
                        ls_done_out  <= 1'b1;
                    end
                end
                default: begin
                    if_done_out <= 1'b0;
                    ls_done_out <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
